// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding a UART serialiser.
// Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Queued bytes go out back-to-back; every bit boundary is a bd_rate cycle.
//
// Handshake: a byte is pushed on any clk edge where tx_valid && tx_ready.
// tx_ready is combinational (FIFO not full). tx_valid may be held across
// cycles, and a push attempted while full is dropped with no side effects.
module uart_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bd_rate,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C   = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic          ODD_BIT   = (PARITY_ODD != 0);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    logic [7:0]    fifo_head;

    // FSM and frame datapath (state is kept visible for checker binding)
    state_t     state, state_d;
    logic [7:0] shift, shift_d;
    logic [2:0] bit_idx, bit_idx_d;
    logic       stop_cnt, stop_cnt_d;
    logic       par_bit, par_bit_d;
    logic       tx_d;

    assign push          = tx_valid && tx_ready;
    assign fifo_nonempty = (count != '0);
    assign fifo_head     = mem[rd_ptr];

    // FIFO data write; contents need no reset because count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // State register; tx is a flop that only moves on bit boundaries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shift    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_d;
            shift    <= shift_d;
            bit_idx  <= bit_idx_d;
            stop_cnt <= stop_cnt_d;
            par_bit  <= par_bit_d;
            if (bd_rate) begin
                tx <= tx_d;
            end
        end
    end

    // Next-state logic: everything advances only on bd_rate cycles
    always_comb begin
        state_d    = state;
        shift_d    = shift;
        bit_idx_d  = bit_idx;
        stop_cnt_d = stop_cnt;
        par_bit_d  = par_bit;
        pop        = 1'b0;
        if (bd_rate) begin
            case (state)
                IDLE: begin
                    if (fifo_nonempty) begin
                        pop       = 1'b1;
                        state_d   = START;
                        shift_d   = fifo_head;
                        par_bit_d = (^fifo_head) ^ ODD_BIT;
                    end
                end
                START: begin
                    // bit 0 goes on the line at this edge, so drop it from the shifter
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    shift_d   = {1'b0, shift[7:1]};
                end
                DATA: begin
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end
                PARITY: begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (stop_cnt == STOP_LAST) begin
                        if (fifo_nonempty) begin
                            pop       = 1'b1;
                            state_d   = START;
                            shift_d   = fifo_head;
                            par_bit_d = (^fifo_head) ^ ODD_BIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs: line level for the state being entered, plus status flags
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift[0];
            PARITY:  tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
        tx_ready = (count < DEPTH_C);
        tx_busy  = (state != IDLE) || fifo_nonempty;
    end

endmodule
